mlp_train_sequencer: RTL and testbench
======================================

// Module: mlp_train_sequencer
// PURPOSE
//  Synthesisable training/evaluation driver for MLP: holds a SAMPLES-deep dataset, streams it to the
//  MLP once per cycle for num_epochs epochs (TRAIN pass then EVAL pass per epoch), scores each EVAL
//  prediction against a threshold and reports per-epoch classification counts. Sits between a host
//  load port and the MLP instance; replaces the hand-written stimulus loop for on-chip training.
// PARAMETERS
//  INPUTS       2   MLP input count (width of values[])
//  OUTPUTS      1   MLP output count (width of expected[]/prediction[])
//  SAMPLES      4   dataset depth, >=1
//  EPOCH_W      16  width of epoch counters
//  MLP_LATENCY  1   cycles from values/training presented to matching prediction valid, >=1
// PORTS
//  clk                 in   1                 clock
//  rst                 in   1                 synchronous active-high reset
//  ld_valid            in   1                 write one dataset entry (IDLE/DONE only)
//  ld_idx              in   $clog2(SAMPLES)   entry index; >=SAMPLES ignored
//  ld_values           in   sfp[INPUTS]       entry inputs
//  ld_expected         in   sfp[OUTPUTS]      entry targets
//  start               in   1                 begin run (IDLE/DONE only)
//  num_epochs          in   EPOCH_W           epochs to run, latched at start
//  cfg_learning_rate   in   sfp               latched at start
//  cfg_threshold       in   sfp               classification threshold, latched at start
//  cfg_hidden_act      in   act_func          latched at start
//  cfg_output_act      in   act_func          latched at start
//  values              out  sfp[INPUTS]       to MLP
//  expected            out  sfp[OUTPUTS]      to MLP
//  training            out  1                 to MLP; 1 only in TRAIN
//  learning_rate       out  sfp               to MLP
//  hidden_activation   out  act_func          to MLP
//  output_activation   out  act_func          to MLP
//  prediction          in   sfp[OUTPUTS]      from MLP
//  busy                out  1                 state not IDLE/DONE
//  done                out  1                 one-cycle pulse at run end
//  epoch_cnt           out  EPOCH_W           completed epochs
//  correct_cnt         out  $clog2(SAMPLES*OUTPUTS+1)  matches in last completed EVAL pass
//  eval_valid          out  1                 one scored sample this cycle
// BEHAVIOUR
//  Reset: state=IDLE; values/expected=0; training=0; learning_rate=0; activations=ReLU; busy=0;
//   done=0; epoch_cnt=0; correct_cnt=0; eval_valid=0; score delay line cleared. Dataset RAM not reset.
//  FSM: IDLE -start-> TRAIN (S cycles, idx 0..S-1, training=1) -> EVAL (S cycles, idx 0..S-1,
//   training=0) -> DRAIN (MLP_LATENCY cycles) -> epoch_cnt++; TRAIN if epoch_cnt<num_epochs else DONE.
//   DONE asserts done for one cycle, stays DONE (busy=0) until start or rst.
//  Timing: start seen at cycle 0 -> first TRAIN sample driven cycle 1; epoch length 2*S+L;
//   done high at cycle E*(2S+L)+1. training and values switch on the same edge, no bubbles.
//  num_epochs=0: run one EVAL+DRAIN (score untrained net), epoch_cnt stays 0, then DONE.
//  Scoring: EVAL issue pushes (valid) into L-deep delay line; at its output sample
//   prediction[o] per o; match = (prediction[o]<thr)==(expected_d[o]<thr), signed compare.
//   Running count cleared at EVAL entry; correct_cnt updated only at DRAIN exit (holds previous value
//   during a pass). eval_valid mirrors delay-line output.
//  Ignored: start while busy; ld_valid while busy; ld_idx>=SAMPLES. ld_valid and start same cycle:
//   write completes, run uses new entry.
//  rst mid-run: immediate return to IDLE with reset values; partial count discarded.
// CONFIGURATION
//  MLP_SEQ_EARLY_STOP_EN defined: at DRAIN exit, if correct_cnt==SAMPLES*OUTPUTS go to DONE
//   regardless of remaining epochs (epoch_cnt counts the finished epoch). Undefined: always runs
//   num_epochs epochs; no extra logic.
// STRUCTURE
//  Common gains typedef enum seq_state_e {SEQ_IDLE,SEQ_TRAIN,SEQ_EVAL,SEQ_DRAIN,SEQ_DONE}.
//  sfp, ONE, HALF, act_func come from FixedPoint/Common unchanged.
//  Sub-module mlp_sample_store: SAMPLES-entry register file, 1 write port, 1 comb read port.
// TESTING (stub MLP: prediction = ONE after MLP_LATENCY unless noted; S=4, L=1)
//  1 XOR set loaded, num_epochs=2 -> training=1 cycles 1-4, 10-13; done at cycle 19; epoch_cnt=2;
//    correct_cnt=2.
//  2 MLP_SEQ_EARLY_STOP_EN, stub pred=expected, num_epochs=50 -> done at cycle 10, epoch_cnt=1,
//    correct_cnt=4; without macro done at cycle 451, epoch_cnt=50.
//  3 num_epochs=0 -> training never 1, done at cycle 6, epoch_cnt=0, correct_cnt=2.
//  4 rst at cycle 7 (EVAL) -> next cycle busy=0, training=0, correct_cnt=0; restart reproduces test 1.
//  5 start and ld_valid(idx 0) while busy -> ignored: run length and RAM unchanged; ld_idx=4 ignored.
//  6 real MLP, lr=0x1999999A, ReLU/Sigmoid, thr=HALF, 100 epochs -> done at cycle 901; correct_cnt
//    equals bench recount of eval_valid-cycle predictions.

Source files
------------

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer: fixed-point format, activation
// selector and sequencer states.
package mlp_train_sequencer_pkg;

    localparam int unsigned SFP_W  = 32;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned ACT_W  = 2;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE  = 32'sh0001_0000;
    localparam sfp HALF = 32'sh0000_8000;

    typedef enum logic [ACT_W-1:0] {
        ACT_RELU    = 2'd0,
        ACT_SIGMOID = 2'd1,
        ACT_TANH    = 2'd2,
        ACT_LINEAR  = 2'd3
    } act_func;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_TRAIN,
        SEQ_EVAL,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    // Signed classification of a value against the threshold.
    function automatic logic sfp_below(input sfp a, input sfp thr);
        return a < thr;
    endfunction

endpackage

// File: rtl/mlp_sample_store.sv
// Dataset register file: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module mlp_sample_store #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_c_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mlp_train_sequencer.sv
// Streams a stored dataset to an MLP for a number of epochs (TRAIN then EVAL pass each)
// and scores the EVAL predictions. Optional MLP_SEQ_EARLY_STOP_EN ends the run once an EVAL pass is perfect.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int unsigned INPUTS      = 2,
    parameter int unsigned OUTPUTS     = 1,
    parameter int unsigned SAMPLES     = 4,
    parameter int unsigned EPOCH_W     = 16,
    parameter int unsigned MLP_LATENCY = 1,
    localparam int unsigned IDX_W      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
    localparam int unsigned CORR_W     = $clog2(SAMPLES * OUTPUTS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid_i,
    input  logic [IDX_W-1:0]           ld_idx_i,
    input  logic [INPUTS*SFP_W-1:0]    ld_values_i,
    input  logic [OUTPUTS*SFP_W-1:0]   ld_expected_i,
    input  logic                       start_i,
    input  logic [EPOCH_W-1:0]         num_epochs_i,
    input  logic [SFP_W-1:0]           cfg_learning_rate_i,
    input  logic [SFP_W-1:0]           cfg_threshold_i,
    input  logic [ACT_W-1:0]           cfg_hidden_act_i,
    input  logic [ACT_W-1:0]           cfg_output_act_i,
    output logic [INPUTS*SFP_W-1:0]    values_o,
    output logic [OUTPUTS*SFP_W-1:0]   expected_o,
    output logic                       training_o,
    output logic [SFP_W-1:0]           learning_rate_o,
    output logic [ACT_W-1:0]           hidden_activation_o,
    output logic [ACT_W-1:0]           output_activation_o,
    input  logic [OUTPUTS*SFP_W-1:0]   prediction_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [EPOCH_W-1:0]         epoch_cnt_o,
    output logic [CORR_W-1:0]          correct_cnt_o,
    output logic                       eval_valid_o
);

    localparam int unsigned IN_W   = INPUTS * SFP_W;
    localparam int unsigned OUT_W  = OUTPUTS * SFP_W;
    localparam int unsigned ENT_W  = IN_W + OUT_W;
    localparam int unsigned PH_MAX = (SAMPLES > MLP_LATENCY) ? SAMPLES : MLP_LATENCY;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned DL_LST = MLP_LATENCY - 1;

    localparam logic [PH_W-1:0]   LAST_SMP   = PH_W'(SAMPLES - 1);
    localparam logic [PH_W-1:0]   LAST_DRN   = PH_W'(MLP_LATENCY - 1);
    localparam logic [CORR_W-1:0] FULL_SCORE = CORR_W'(SAMPLES * OUTPUTS);

    seq_state_e          state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [EPOCH_W-1:0]  nep_q, nep_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [CORR_W-1:0]   corr_q, corr_d;
    logic [CORR_W-1:0]   run_q, run_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                training_q, training_d;
    logic [IN_W-1:0]     values_q, values_d;
    logic [OUT_W-1:0]    expected_q, expected_d;
    sfp                  lr_q, lr_d;
    sfp                  thr_q, thr_d;
    logic [ACT_W-1:0]    hact_q, hact_d;
    logic [ACT_W-1:0]    oact_q, oact_d;

    logic                dl_vld_q [MLP_LATENCY];
    logic [OUT_W-1:0]    dl_exp_q [MLP_LATENCY];

    logic                wr_en_c;
    logic [ENT_W-1:0]    wr_data_c;
    logic [IDX_W-1:0]    rd_idx_c;
    logic [ENT_W-1:0]    rd_data_c;
    logic [ENT_W-1:0]    entry_c;
    logic [CORR_W-1:0]   score_inc_c;

    // Host writes only land while idle/done and for in-range indices.
    assign wr_en_c   = ld_valid_i && !busy_q &&
                       ({1'b0, ld_idx_i} < (IDX_W + 1)'(SAMPLES));
    assign wr_data_c = {ld_expected_i, ld_values_i};
    assign rd_idx_c  = IDX_W'(ph_d);

    mlp_sample_store #(
        .DEPTH  (SAMPLES),
        .DATA_W (ENT_W),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk         (clk),
        .wr_en_i     (wr_en_c),
        .wr_idx_i    (ld_idx_i),
        .wr_data_i   (wr_data_c),
        .rd_idx_i    (rd_idx_c),
        .rd_data_c_o (rd_data_c)
    );

    // Forward a same-cycle write so a start issued with a load sees the new entry.
    assign entry_c = (wr_en_c && (ld_idx_i == rd_idx_c)) ? wr_data_c : rd_data_c;

    // Score the sample leaving the delay line against the live prediction.
    always_comb begin
        score_inc_c = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (dl_vld_q[DL_LST] &&
                (sfp_below(sfp'(prediction_i[o*SFP_W +: SFP_W]), thr_q) ==
                 sfp_below(sfp'(dl_exp_q[DL_LST][o*SFP_W +: SFP_W]), thr_q))) begin
                score_inc_c = score_inc_c + CORR_W'(1);
            end
        end
    end

    // Sequencer next-state, epoch bookkeeping and config latching.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        nep_d   = nep_q;
        epoch_d = epoch_q;
        corr_d  = corr_q;
        run_d   = run_q + score_inc_c;
        done_d  = 1'b0;
        lr_d    = lr_q;
        thr_d   = thr_q;
        hact_d  = hact_q;
        oact_d  = oact_q;

        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (start_i) begin
                    nep_d   = num_epochs_i;
                    lr_d    = sfp'(cfg_learning_rate_i);
                    thr_d   = sfp'(cfg_threshold_i);
                    hact_d  = cfg_hidden_act_i;
                    oact_d  = cfg_output_act_i;
                    epoch_d = '0;
                    ph_d    = '0;
                    if (num_epochs_i == '0) begin
                        state_d = SEQ_EVAL;
                        run_d   = '0;
                    end else begin
                        state_d = SEQ_TRAIN;
                    end
                end
            end
            SEQ_TRAIN: begin
                if (ph_q == LAST_SMP) begin
                    ph_d    = '0;
                    state_d = SEQ_EVAL;
                    run_d   = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            SEQ_EVAL: begin
                if (ph_q == LAST_SMP) begin
                    ph_d    = '0;
                    state_d = SEQ_DRAIN;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            SEQ_DRAIN: begin
                if (ph_q == LAST_DRN) begin
                    ph_d    = '0;
                    corr_d  = run_d;
                    state_d = SEQ_DONE;
                    // A zero-epoch run is a single evaluation and does not count as an epoch.
                    if (nep_q != '0) begin
                        epoch_d = epoch_q + EPOCH_W'(1);
                        if (epoch_d < nep_q) begin
                            state_d = SEQ_TRAIN;
                        end
`ifdef MLP_SEQ_EARLY_STOP_EN
                        if (run_d == FULL_SCORE) begin
                            state_d = SEQ_DONE;
                        end
`endif
                    end
                    done_d = (state_d == SEQ_DONE);
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // MLP-facing outputs are loaded on the edge that enters each TRAIN/EVAL cycle.
    always_comb begin
        values_d   = values_q;
        expected_d = expected_q;
        training_d = (state_d == SEQ_TRAIN);
        busy_d     = (state_d == SEQ_TRAIN) || (state_d == SEQ_EVAL) || (state_d == SEQ_DRAIN);
        if ((state_d == SEQ_TRAIN) || (state_d == SEQ_EVAL)) begin
            values_d   = entry_c[IN_W-1:0];
            expected_d = entry_c[ENT_W-1:IN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            ph_q       <= '0;
            nep_q      <= '0;
            epoch_q    <= '0;
            corr_q     <= '0;
            run_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            training_q <= 1'b0;
            values_q   <= '0;
            expected_q <= '0;
            lr_q       <= '0;
            thr_q      <= '0;
            hact_q     <= ACT_RELU;
            oact_q     <= ACT_RELU;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            nep_q      <= nep_d;
            epoch_q    <= epoch_d;
            corr_q     <= corr_d;
            run_q      <= run_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            training_q <= training_d;
            values_q   <= values_d;
            expected_q <= expected_d;
            lr_q       <= lr_d;
            thr_q      <= thr_d;
            hact_q     <= hact_d;
            oact_q     <= oact_d;
        end
    end

    // Delay line aligning each EVAL issue with its prediction MLP_LATENCY cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MLP_LATENCY; i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_exp_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0] <= (state_q == SEQ_EVAL);
            dl_exp_q[0] <= expected_q;
            for (int i = 1; i < MLP_LATENCY; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_exp_q[i] <= dl_exp_q[i-1];
            end
        end
    end

    assign values_o            = values_q;
    assign expected_o          = expected_q;
    assign training_o          = training_q;
    assign learning_rate_o     = lr_q;
    assign hidden_activation_o = hact_q;
    assign output_activation_o = oact_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign epoch_cnt_o         = epoch_q;
    assign correct_cnt_o       = corr_q;
    assign eval_valid_o        = dl_vld_q[DL_LST];

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Bench for mlp_train_sequencer (S=4, L=1) with a stub MLP whose prediction mode is
// selectable: constant ONE, echo of expected, or sum of the two inputs.
module tb_mlp_train_sequencer;
    import mlp_train_sequencer_pkg::*;

    localparam int S   = 4;
    localparam int L   = 1;
    localparam int EPL = 2 * S + L;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [1:0]  ld_idx;
    logic [63:0] ld_values;
    logic [31:0] ld_expected;
    logic        start;
    logic [15:0] num_epochs;
    logic [31:0] cfg_lr;
    logic [31:0] cfg_thr;
    logic [1:0]  cfg_hact;
    logic [1:0]  cfg_oact;
    logic [63:0] values_o;
    logic [31:0] expected_o;
    logic        training_o;
    logic [31:0] learning_rate_o;
    logic [1:0]  hidden_activation_o;
    logic [1:0]  output_activation_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] epoch_cnt_o;
    logic [2:0]  correct_cnt_o;
    logic        eval_valid_o;
    sfp          pred_q;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;
    sfp ds_v0 [S];
    sfp ds_v1 [S];
    sfp ds_e  [S];

    always #5 clk = ~clk;

    mlp_train_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .ld_valid_i          (ld_valid),
        .ld_idx_i            (ld_idx),
        .ld_values_i         (ld_values),
        .ld_expected_i       (ld_expected),
        .start_i             (start),
        .num_epochs_i        (num_epochs),
        .cfg_learning_rate_i (cfg_lr),
        .cfg_threshold_i     (cfg_thr),
        .cfg_hidden_act_i    (cfg_hact),
        .cfg_output_act_i    (cfg_oact),
        .values_o            (values_o),
        .expected_o          (expected_o),
        .training_o          (training_o),
        .learning_rate_o     (learning_rate_o),
        .hidden_activation_o (hidden_activation_o),
        .output_activation_o (output_activation_o),
        .prediction_i        (pred_q),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .epoch_cnt_o         (epoch_cnt_o),
        .correct_cnt_o       (correct_cnt_o),
        .eval_valid_o        (eval_valid_o)
    );

    // Stub MLP with one cycle of latency.
    always_ff @(posedge clk) begin
        case (mode)
            0:       pred_q <= ONE;
            1:       pred_q <= sfp'(expected_o);
            default: pred_q <= sfp'(values_o[31:0]) + sfp'(values_o[63:32]);
        endcase
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference scoring: what the stub predicts for each stored sample, classified per the threshold.
    function automatic int model_correct(input int md, input sfp thr);
        int n = 0;
        sfp p;
        for (int k = 0; k < S; k++) begin
            if (md == 0)      p = ONE;
            else if (md == 1) p = ds_e[k];
            else              p = ds_v0[k] + ds_v1[k];
            if ((p < thr) == (ds_e[k] < thr)) n++;
        end
        return n;
    endfunction

    task automatic load(input int k, input sfp v0, input sfp v1, input sfp e);
        ld_valid    = 1'b1;
        ld_idx      = 2'(k);
        ld_values   = {v1, v0};
        ld_expected = e;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ds_v0[k] = v0;
        ds_v1[k] = v1;
        ds_e[k]  = e;
    endtask

    task automatic check_reset_state(input string nm);
        @(negedge clk);
        chk({nm, ".busy"},     longint'(busy_o), 0);
        chk({nm, ".training"}, longint'(training_o), 0);
        chk({nm, ".done"},     longint'(done_o), 0);
        chk({nm, ".epoch"},    longint'(epoch_cnt_o), 0);
        chk({nm, ".correct"},  longint'(correct_cnt_o), 0);
        chk({nm, ".evalv"},    longint'(eval_valid_o), 0);
        chk({nm, ".values"},   longint'(values_o != '0), 0);
        chk({nm, ".lr"},       longint'(learning_rate_o), 0);
        chk({nm, ".hact"},     longint'(hidden_activation_o), longint'(ACT_RELU));
        @(posedge clk); #1;
    endtask

    // Runs one start..done sequence; optional busy-time poke and load-with-start.
    task automatic run_test(input string nm, input int nep, input int md, input sfp thr,
                            input int poke, input bit ld_w_start,
                            input int exp_done, input int exp_ep, input int exp_corr);
        int   done_at   = -1;
        int   train_err = 0;
        int   ev        = 0;
        logic exp_tr;
        sfp   lr;
        logic [1:0] ha;
        logic [1:0] oa;
        lr   = sfp'($urandom);
        ha   = 2'($urandom_range(3));
        oa   = 2'($urandom_range(3));
        mode = md;
        start      = 1'b1;
        num_epochs = 16'(nep);
        cfg_thr    = thr;
        cfg_lr     = lr;
        cfg_hact   = ha;
        cfg_oact   = oa;
        if (ld_w_start) begin
            ld_valid    = 1'b1;
            ld_idx      = 2'd0;
            ld_values   = '0;
            ld_expected = ONE;
            ds_v0[0] = '0;
            ds_v1[0] = '0;
            ds_e[0]  = ONE;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        for (int c = 1; c <= exp_done + 20 && done_at < 0; c++) begin
            if (c == poke) begin
                start       = 1'b1;
                num_epochs  = 16'(nep + 5);
                ld_valid    = 1'b1;
                ld_idx      = 2'd0;
                ld_values   = '0;
                ld_expected = ONE;
            end else begin
                start    = 1'b0;
                ld_valid = 1'b0;
            end
            @(negedge clk);
            exp_tr = (nep > 0) && (c < exp_done) && (((c - 1) % EPL) < S);
            if (training_o !== exp_tr) train_err++;
            if (eval_valid_o) ev++;
            if (c == 1) begin
                chk({nm, ".busy1"}, longint'(busy_o), 1);
                chk({nm, ".lr"},    longint'(learning_rate_o), longint'(unsigned'(lr)));
                chk({nm, ".hact"},  longint'(hidden_activation_o), longint'(ha));
                chk({nm, ".oact"},  longint'(output_activation_o), longint'(oa));
            end
            if (done_o) done_at = c;
            @(posedge clk); #1;
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        chk({nm, ".done_cycle"}, done_at, exp_done);
        chk({nm, ".epoch_cnt"},  longint'(epoch_cnt_o), exp_ep);
        chk({nm, ".correct"},    longint'(correct_cnt_o), exp_corr);
        chk({nm, ".train_err"},  train_err, 0);
        chk({nm, ".eval_cnt"},   ev, (nep == 0) ? S : exp_ep * S);
        @(negedge clk);
        chk({nm, ".done_pulse"}, longint'(done_o), 0);
        chk({nm, ".busy_after"}, longint'(busy_o), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string nm;
        int    nep;
        int    mode;
        int    poke;
        int    done_c;
        int    ep;
        int    corr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"xor_e2",     2,  0, 0, 19, 2, 2};
        vecs[1] = '{"xor_e0",     0,  0, 0, 6,  0, 2};
`ifdef MLP_SEQ_EARLY_STOP_EN
        vecs[2] = '{"early_e50",  50, 1, 0, 10, 1, 4};
`else
        vecs[2] = '{"full_e50",   50, 1, 0, 451, 50, 4};
`endif
        vecs[3] = '{"sum_e1",     1,  2, 0, 10, 1, 3};
        vecs[4] = '{"busy_poke",  1,  2, 3, 10, 1, 3};
        vecs[5] = '{"ram_intact", 0,  2, 0, 6,  0, 3};

        rst = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_values = '0; ld_expected = '0;
        start = 1'b0; num_epochs = '0; cfg_lr = '0; cfg_thr = '0; cfg_hact = '0; cfg_oact = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        load(0, 32'sd0, 32'sd0, 32'sd0);
        load(1, 32'sd0, ONE,    ONE);
        load(2, ONE,    32'sd0, ONE);
        load(3, ONE,    ONE,    32'sd0);

        for (int i = 0; i < 6; i++) begin
            run_test(vecs[i].nm, vecs[i].nep, vecs[i].mode, HALF, vecs[i].poke, 1'b0,
                     vecs[i].done_c, vecs[i].ep, vecs[i].corr);
        end

        // Load and start in the same cycle: run must see the new entry 0.
        run_test("ld_with_start", 0, 2, HALF, 0, 1'b1, 6, 0, 2);
        load(0, 32'sd0, 32'sd0, 32'sd0);

        // Reset in the middle of EVAL, then a clean rerun.
        mode = 1; start = 1'b1; num_epochs = 16'd2; cfg_thr = HALF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) rst = 1'b1;
            if (c == 6) begin
                @(negedge clk);
                chk("mid_pass_hold.correct", longint'(correct_cnt_o), 2);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        check_reset_state("mid_rst");
        run_test("restart_e2", 2, 0, HALF, 0, 1'b0, 19, 2, 2);

        // Randomized datasets against the reference scoring model.
        for (int r = 0; r < 8; r++) begin
            int nep, md, corr, ep, dn;
            bit es;
            sfp thr;
            for (int k = 0; k < S; k++) begin
                load(k, sfp'($urandom_range(32'h0004_0000)) - 2 * ONE,
                        sfp'($urandom_range(32'h0004_0000)) - 2 * ONE,
                        sfp'($urandom_range(32'h0004_0000)) - 2 * ONE);
            end
            thr  = sfp'($urandom_range(32'h0002_0000)) - ONE;
            nep  = int'($urandom_range(3));
            md   = int'($urandom_range(2));
            corr = model_correct(md, thr);
`ifdef MLP_SEQ_EARLY_STOP_EN
            es = 1'b1;
`else
            es = 1'b0;
`endif
            ep = (nep == 0) ? 0 : ((es && corr == S) ? 1 : nep);
            dn = ((nep == 0) ? (S + L) : ep * EPL) + 1;
            run_test($sformatf("rand%0d", r), nep, md, thr, 0, 1'b0, dn, ep, corr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
